kairo_mtimer: RTL and testbench
===============================

Name: kairo_mtimer

Overview:
Memory-mapped machine timer and software-interrupt source for the kairo core. It holds the 64-bit mtime and mtimecmp counters, a prescaler and the msip bit. It drives TIMER_EXPIRED (level) and SW_INTERRUPT (pulse) directly into kairo_csr. It sits on the core's peripheral bus, upstream of the CSR file.

Parameters:
PRESCALE_W, 8, width of the prescale divider field.
PRESCALE_RST, 0, reset value of the prescale field (0 = tick every cycle).

Ports:
CLK  input  1  clock.
RST_N  input  1  asynchronous active-low reset.
BUS_EN  input  1  access strobe, one cycle per access.
BUS_WE  input  1  1 = write, 0 = read.
BUS_ADDR  input  5  byte offset; bits [1:0] are ignored.
BUS_WDATA  input  32  write data.
BUS_WSTRB  input  4  byte write enables.
BUS_RDATA  output  32  read data, valid when BUS_RVALID is high.
BUS_RVALID  output  1  one-cycle pulse, asserted exactly 1 cycle after a read strobe.
DBG_HALT  input  1  core is in debug mode; freezes mtime.
TIMER_EXPIRED  output  1  registered (mtime >= mtimecmp).
SW_INTERRUPT  output  1  one-cycle pulse on a 0->1 transition of msip.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low; it clears state immediately, with no clock edge required.
- Register map (offsets):
  - 0x00 mtime[31:0]
  - 0x04 mtime[63:32]
  - 0x08 mtimecmp[31:0]
  - 0x0C mtimecmp[63:32]
  - 0x10 msip: bit0 only; other bits read 0
  - 0x14 ctrl: bit31 = EN, [PRESCALE_W-1:0] = PRESCALE; other bits read 0
  - 0x18 and 0x1C: unmapped; reads return 0, writes are ignored.
- Reset values:
  - mtime = 0; mtimecmp = all ones; msip = 0; EN = 1; PRESCALE = PRESCALE_RST.
  - Prescale counter = 0; hi shadow = 0.
  - BUS_RDATA = 0; BUS_RVALID = 0; TIMER_EXPIRED = 0; SW_INTERRUPT = 0.
- Writes: take effect at the clock edge of the strobe cycle. Each byte is qualified by its BUS_WSTRB bit. No response is returned.
- Reads: BUS_RDATA and BUS_RVALID are registered, giving 1-cycle latency. Back-to-back reads are supported every cycle.
- Atomic 64-bit read: a read of 0x00 captures mtime[63:32] into the hi shadow in the same cycle. A read of 0x04 returns the shadow, not live mtime[63:32]. Software reads lo then hi.
- Prescaler:
  - When EN = 1 and DBG_HALT = 0, the prescale counter increments every cycle.
  - When the counter equals PRESCALE, it resets to 0 and mtime increments by 1 (a tick).
  - When EN = 0 or DBG_HALT = 1, the counter and mtime hold.
- mtime arithmetic: a full 64-bit increment with carry from lo to hi. It wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- Write priority:
  - A bus write to 0x00 or 0x04 in the same cycle as a tick wins; the tick is dropped.
  - Any mtime write also clears the prescale counter.
  - A PRESCALE write clears the prescale counter.
- TIMER_EXPIRED: registered each cycle from the current register values as an unsigned 64-bit compare (mtime >= mtimecmp). It therefore lags a register change by 1 cycle. It is level-sensitive and clears only when mtime or mtimecmp changes so that the compare fails.
- msip and SW_INTERRUPT:
  - msip is written via 0x10 bit0 (WSTRB[0]).
  - SW_INTERRUPT is registered: high for exactly one cycle after the edge at which msip goes 0->1.
  - Writing 1 while msip is already 1 produces no pulse. Writing 0 clears msip with no pulse.
- Reset mid-operation: all state returns to reset values immediately. An outstanding read gets no BUS_RVALID.

Test Plan:
- Reset release, idle 10 cycles, PRESCALE = 0 -> read 0x00 returns a value >= 10, and BUS_RVALID occurs exactly 1 cycle after the strobe; TIMER_EXPIRED = 0.
- Write PRESCALE = 3, mtime = 0 -> mtime increments once per 4 cycles; after 40 cycles, lo = 10 ± 1.
- Write mtime = 0x0000_0000_FFFF_FFFE, let it tick 2, read lo then hi -> lo = 0, hi = 1. Then write hi = 5 without reading lo, read 0x04 -> returns the old shadow value 1.
- mtimecmp = 20, mtime = 0, PRESCALE = 0 -> TIMER_EXPIRED rises 1 cycle after mtime reaches 20. Then write mtimecmp_hi = 1 -> TIMER_EXPIRED falls 1 cycle later.
- Write msip = 1, then 1 again, then 0, then 1 -> exactly two SW_INTERRUPT pulses, each 1 cycle wide; read 0x10 returns 1.
- DBG_HALT high for 8 cycles, and separately EN = 0 -> mtime is frozen during both. Mtime write coinciding with a tick -> the written value is held. Assert RST_N low mid-count -> mtime = 0 and TIMER_EXPIRED = 0 immediately, with no clock edge.

Source files
------------

// File: rtl/kairo_mtimer.sv
// Machine timer and software-interrupt source: 64-bit mtime/mtimecmp, prescaler,
// msip, with a small register bus (registered reads, strobed byte writes).
module kairo_mtimer #(
  parameter int PRESCALE_W   = 8,
  parameter int PRESCALE_RST = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        BUS_EN,
  input  logic        BUS_WE,
  input  logic [4:0]  BUS_ADDR,
  input  logic [31:0] BUS_WDATA,
  input  logic [3:0]  BUS_WSTRB,
  output logic [31:0] BUS_RDATA,
  output logic        BUS_RVALID,
  input  logic        DBG_HALT,
  output logic        TIMER_EXPIRED,
  output logic        SW_INTERRUPT
);

  // Bus handshake: BUS_EN is a single-cycle strobe with no back-pressure; a read
  // strobe always yields BUS_RVALID with BUS_RDATA on the following cycle.
  localparam int         PS_BYTES = (PRESCALE_W + 7) / 8;
  localparam logic [3:0] PS_STRB  = 4'((1 << PS_BYTES) - 1);

  logic [63:0]           mtime, mtime_next;
  logic [63:0]           mtimecmp;
  logic [31:0]           hi_shadow;
  logic                  msip;
  logic                  en, en_next;
  logic [PRESCALE_W-1:0] prescale, prescale_next;
  logic [PRESCALE_W-1:0] pcnt, pcnt_next;
  logic [31:0]           rd_word;

  logic [2:0] word;
  logic       wr, rd, any_strb;
  logic       wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_msip, wr_ctrl;
  logic       ps_wr, run, tick;
  logic       unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

  assign unused_addr = ^BUS_ADDR[1:0];
  assign word        = BUS_ADDR[4:2];
  assign wr          = BUS_EN & BUS_WE;
  assign rd          = BUS_EN & ~BUS_WE;
  assign any_strb    = |BUS_WSTRB;
  assign wr_mtime_lo = wr & any_strb & (word == 3'd0);
  assign wr_mtime_hi = wr & any_strb & (word == 3'd1);
  assign wr_cmp_lo   = wr & (word == 3'd2);
  assign wr_cmp_hi   = wr & (word == 3'd3);
  assign wr_msip     = wr & (word == 3'd4) & BUS_WSTRB[0];
  assign wr_ctrl     = wr & (word == 3'd5);
  assign ps_wr       = wr_ctrl & |(BUS_WSTRB & PS_STRB);
  assign run         = en & ~DBG_HALT;
  assign tick        = run & (pcnt == prescale);

  always_comb begin
    en_next       = en;
    prescale_next = prescale;
    if (wr_ctrl) begin
      if (BUS_WSTRB[3]) en_next = BUS_WDATA[31];
      for (int b = 0; b < PRESCALE_W; b++) begin
        if (BUS_WSTRB[b/8]) prescale_next[b] = BUS_WDATA[b];
      end
    end
  end

  // A bus write to mtime beats a coincident tick; the tick is simply lost.
  always_comb begin
    mtime_next = mtime;
    if (wr_mtime_lo)      mtime_next[31:0]  = merge_bytes(mtime[31:0], BUS_WDATA, BUS_WSTRB);
    else if (wr_mtime_hi) mtime_next[63:32] = merge_bytes(mtime[63:32], BUS_WDATA, BUS_WSTRB);
    else if (tick)        mtime_next        = mtime + 64'd1;
  end

  always_comb begin
    pcnt_next = pcnt;
    if (wr_mtime_lo | wr_mtime_hi | ps_wr) pcnt_next = '0;
    else if (run)                          pcnt_next = tick ? '0 : pcnt + PRESCALE_W'(1);
  end

  always_comb begin
    rd_word = '0;
    case (word)
      3'd0: rd_word = mtime[31:0];
      3'd1: rd_word = hi_shadow;
      3'd2: rd_word = mtimecmp[31:0];
      3'd3: rd_word = mtimecmp[63:32];
      3'd4: rd_word = {31'd0, msip};
      3'd5: begin
        rd_word                 = 32'(prescale);
        rd_word[31]             = en;
      end
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mtime         <= '0;
      mtimecmp      <= '1;
      hi_shadow     <= '0;
      msip          <= 1'b0;
      en            <= 1'b1;
      prescale      <= PRESCALE_W'(PRESCALE_RST);
      pcnt          <= '0;
      BUS_RDATA     <= '0;
      BUS_RVALID    <= 1'b0;
      TIMER_EXPIRED <= 1'b0;
      SW_INTERRUPT  <= 1'b0;
    end else begin
      mtime      <= mtime_next;
      pcnt       <= pcnt_next;
      en         <= en_next;
      prescale   <= prescale_next;
      if (wr_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], BUS_WDATA, BUS_WSTRB);
      if (wr_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], BUS_WDATA, BUS_WSTRB);
      if (wr_msip)   msip            <= BUS_WDATA[0];
      SW_INTERRUPT  <= wr_msip & BUS_WDATA[0] & ~msip;
      TIMER_EXPIRED <= (mtime >= mtimecmp);
      BUS_RVALID    <= rd;
      if (rd) BUS_RDATA <= rd_word;
      // Reading the low word freezes the high word so a lo-then-hi pair is coherent.
      if (rd && word == 3'd0) hi_shadow <= mtime[63:32];
    end
  end

endmodule

// File: tb/tb_kairo_mtimer.sv
// Directed bench for kairo_mtimer: register map, prescaler, shadowed 64-bit read,
// compare, msip pulse, freeze conditions and asynchronous reset.
module tb_kairo_mtimer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        BUS_EN, BUS_WE;
  logic [4:0]  BUS_ADDR;
  logic [31:0] BUS_WDATA;
  logic [3:0]  BUS_WSTRB;
  logic [31:0] BUS_RDATA;
  logic        BUS_RVALID;
  logic        DBG_HALT;
  logic        TIMER_EXPIRED;
  logic        SW_INTERRUPT;

  int checks = 0;
  int fails  = 0;
  int sw_high = 0;

  kairo_mtimer #(.PRESCALE_W(8), .PRESCALE_RST(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .BUS_EN(BUS_EN), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .BUS_WSTRB(BUS_WSTRB), .BUS_RDATA(BUS_RDATA),
    .BUS_RVALID(BUS_RVALID), .DBG_HALT(DBG_HALT), .TIMER_EXPIRED(TIMER_EXPIRED),
    .SW_INTERRUPT(SW_INTERRUPT)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge CLK) if (SW_INTERRUPT === 1'b1) sw_high++;

  // Driver tasks: inputs change on the falling edge, outputs sampled on the falling edge
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge CLK);
    BUS_EN = 1'b1; BUS_WE = 1'b1; BUS_ADDR = a; BUS_WDATA = d; BUS_WSTRB = s;
    @(negedge CLK);
    BUS_EN = 1'b0; BUS_WE = 1'b0; BUS_WSTRB = 4'h0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic v);
    @(negedge CLK);
    BUS_EN = 1'b1; BUS_WE = 1'b0; BUS_ADDR = a;
    @(negedge CLK);
    BUS_EN = 1'b0;
    d = BUS_RDATA; v = BUS_RVALID;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; BUS_EN = 1'b0; BUS_WE = 1'b0; BUS_ADDR = '0; BUS_WDATA = '0;
    BUS_WSTRB = '0; DBG_HALT = 1'b0;
    #3;
    checks++; if (BUS_RVALID !== 1'b0) begin fails++; $display("FAIL rst_rvalid: got %b expected 0", BUS_RVALID); end
    checks++; if (BUS_RDATA !== 32'd0) begin fails++; $display("FAIL rst_rdata: got %h expected 0", BUS_RDATA); end
    checks++; if (TIMER_EXPIRED !== 1'b0) begin fails++; $display("FAIL rst_expired: got %b expected 0", TIMER_EXPIRED); end
    checks++; if (SW_INTERRUPT !== 1'b0) begin fails++; $display("FAIL rst_swint: got %b expected 0", SW_INTERRUPT); end
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    BUS_EN = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 5'h00;
    checks++; if (BUS_RVALID !== 1'b0) begin fails++; $display("FAIL rd_early: got %b expected 0", BUS_RVALID); end
    @(negedge CLK);
    BUS_EN = 1'b0;
    checks++; if (BUS_RVALID !== 1'b1) begin fails++; $display("FAIL rd_latency: got %b expected 1", BUS_RVALID); end
    checks++; if (BUS_RDATA < 32'd10) begin fails++; $display("FAIL idle_mtime: got %0d expected >= 10", BUS_RDATA); end
    checks++; if (TIMER_EXPIRED !== 1'b0) begin fails++; $display("FAIL idle_expired: got %b expected 0", TIMER_EXPIRED); end
    @(negedge CLK);
    checks++; if (BUS_RVALID !== 1'b0) begin fails++; $display("FAIL rd_pulse: got %b expected 0", BUS_RVALID); end
  endtask

  task automatic test_prescale();
    logic [31:0] d; logic v;
    bus_write(5'h14, 32'h8000_0003, 4'hF);
    bus_write(5'h04, 32'h0, 4'hF);
    bus_write(5'h00, 32'h0, 4'hF);
    repeat (40) @(negedge CLK);
    bus_read(5'h00, d, v);
    checks++; if (d < 32'd9 || d > 32'd11) begin fails++; $display("FAIL prescale_lo: got %0d expected 10+-1", d); end
    bus_read(5'h04, d, v);
    checks++; if (d !== 32'd0) begin fails++; $display("FAIL prescale_hi: got %h expected 0", d); end
  endtask

  task automatic test_carry();
    logic [31:0] d; logic v;
    bus_write(5'h14, 32'h0000_0000, 4'hF);
    bus_write(5'h04, 32'h0, 4'hF);
    bus_write(5'h00, 32'hFFFF_FFFE, 4'hF);
    bus_write(5'h14, 32'h8000_0000, 4'hF);
    @(negedge CLK);
    bus_read(5'h00, d, v);
    checks++; if (d !== 32'd0) begin fails++; $display("FAIL carry_lo: got %h expected 0", d); end
    bus_read(5'h04, d, v);
    checks++; if (d !== 32'd1) begin fails++; $display("FAIL carry_hi: got %h expected 1", d); end
    bus_write(5'h04, 32'd5, 4'hF);
    bus_read(5'h04, d, v);
    checks++; if (d !== 32'd1) begin fails++; $display("FAIL shadow_old: got %h expected 1", d); end
    bus_read(5'h00, d, v);
    bus_read(5'h04, d, v);
    checks++; if (d !== 32'd5) begin fails++; $display("FAIL shadow_new: got %h expected 5", d); end
  endtask

  task automatic test_expire();
    bus_write(5'h14, 32'h0000_0000, 4'hF);
    bus_write(5'h04, 32'h0, 4'hF);
    bus_write(5'h00, 32'h0, 4'hF);
    bus_write(5'h08, 32'd20, 4'hF);
    bus_write(5'h0C, 32'h0, 4'hF);
    @(negedge CLK);
    checks++; if (TIMER_EXPIRED !== 1'b0) begin fails++; $display("FAIL exp_idle: got %b expected 0", TIMER_EXPIRED); end
    bus_write(5'h14, 32'h8000_0000, 4'hF);
    repeat (20) @(negedge CLK);
    checks++; if (TIMER_EXPIRED !== 1'b0) begin fails++; $display("FAIL exp_before: got %b expected 0", TIMER_EXPIRED); end
    @(negedge CLK);
    checks++; if (TIMER_EXPIRED !== 1'b1) begin fails++; $display("FAIL exp_rise: got %b expected 1", TIMER_EXPIRED); end
    bus_write(5'h0C, 32'd1, 4'hF);
    checks++; if (TIMER_EXPIRED !== 1'b1) begin fails++; $display("FAIL exp_lag: got %b expected 1", TIMER_EXPIRED); end
    @(negedge CLK);
    checks++; if (TIMER_EXPIRED !== 1'b0) begin fails++; $display("FAIL exp_fall: got %b expected 0", TIMER_EXPIRED); end
  endtask

  task automatic test_msip();
    logic [31:0] d; logic v;
    sw_high = 0;
    bus_write(5'h10, 32'd1, 4'h1);
    checks++; if (SW_INTERRUPT !== 1'b1) begin fails++; $display("FAIL sw_first: got %b expected 1", SW_INTERRUPT); end
    @(negedge CLK);
    checks++; if (SW_INTERRUPT !== 1'b0) begin fails++; $display("FAIL sw_width: got %b expected 0", SW_INTERRUPT); end
    bus_write(5'h10, 32'd1, 4'h1);
    checks++; if (SW_INTERRUPT !== 1'b0) begin fails++; $display("FAIL sw_repeat: got %b expected 0", SW_INTERRUPT); end
    bus_write(5'h10, 32'd0, 4'h1);
    checks++; if (SW_INTERRUPT !== 1'b0) begin fails++; $display("FAIL sw_clear: got %b expected 0", SW_INTERRUPT); end
    bus_write(5'h10, 32'd1, 4'h1);
    checks++; if (SW_INTERRUPT !== 1'b1) begin fails++; $display("FAIL sw_second: got %b expected 1", SW_INTERRUPT); end
    bus_write(5'h10, 32'hFFFF_FFFE, 4'hE);
    checks++; if (sw_high !== 2) begin fails++; $display("FAIL sw_count: got %0d expected 2", sw_high); end
    bus_read(5'h10, d, v);
    checks++; if (d !== 32'd1) begin fails++; $display("FAIL msip_read: got %h expected 1", d); end
  endtask

  task automatic test_freeze();
    logic [31:0] d; logic v;
    @(negedge CLK);
    DBG_HALT = 1'b1;
    bus_write(5'h04, 32'h0, 4'hF);
    bus_write(5'h00, 32'd100, 4'hF);
    bus_read(5'h00, d, v);
    checks++; if (d !== 32'd100) begin fails++; $display("FAIL halt_start: got %0d expected 100", d); end
    repeat (8) @(negedge CLK);
    bus_read(5'h00, d, v);
    checks++; if (d !== 32'd100) begin fails++; $display("FAIL halt_hold: got %0d expected 100", d); end
    DBG_HALT = 1'b0;
    bus_read(5'h00, d, v);
    checks++; if (d !== 32'd101) begin fails++; $display("FAIL halt_resume: got %0d expected 101", d); end
    bus_write(5'h14, 32'h0, 4'hF);
    bus_write(5'h00, 32'd200, 4'hF);
    bus_read(5'h00, d, v);
    checks++; if (d !== 32'd200) begin fails++; $display("FAIL en0_start: got %0d expected 200", d); end
    repeat (8) @(negedge CLK);
    bus_read(5'h00, d, v);
    checks++; if (d !== 32'd200) begin fails++; $display("FAIL en0_hold: got %0d expected 200", d); end
    bus_read(5'h14, d, v);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL ctrl_off: got %h expected 0", d); end
    bus_write(5'h14, 32'h8000_0005, 4'hF);
    bus_read(5'h14, d, v);
    checks++; if (d !== 32'h8000_0005) begin fails++; $display("FAIL ctrl_read: got %h expected 80000005", d); end
    bus_write(5'h14, 32'h8000_0000, 4'hF);
  endtask

  task automatic test_tick_write();
    logic [31:0] d; logic v;
    bus_write(5'h00, 32'h0000_1234, 4'hF);
    bus_read(5'h00, d, v);
    checks++; if (d !== 32'h0000_1235) begin fails++; $display("FAIL tick_write: got %h expected 00001235", d); end
    bus_read(5'h04, d, v);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL tick_write_hi: got %h expected 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic v;
    bus_write(5'h08, 32'h0, 4'hF);
    bus_write(5'h0C, 32'h0, 4'hF);
    @(negedge CLK);
    checks++; if (TIMER_EXPIRED !== 1'b1) begin fails++; $display("FAIL pre_reset_exp: got %b expected 1", TIMER_EXPIRED); end
    @(negedge CLK);
    BUS_EN = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 5'h00;
    #2 RST_N = 1'b0;
    #1;
    checks++; if (TIMER_EXPIRED !== 1'b0) begin fails++; $display("FAIL async_exp: got %b expected 0", TIMER_EXPIRED); end
    checks++; if (BUS_RDATA !== 32'd0) begin fails++; $display("FAIL async_rdata: got %h expected 0", BUS_RDATA); end
    @(posedge CLK); #1;
    checks++; if (BUS_RVALID !== 1'b0) begin fails++; $display("FAIL async_rvalid: got %b expected 0", BUS_RVALID); end
    @(negedge CLK);
    BUS_EN = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    bus_read(5'h00, d, v);
    checks++; if (d !== 32'd1) begin fails++; $display("FAIL post_reset_mtime: got %0d expected 1", d); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  addrs [5];
    logic [31:0] exps  [5];
    addrs = '{5'h08, 5'h0C, 5'h10, 5'h14, 5'h18};
    exps  = '{32'hFFFF_FFAA, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0};
    bus_write(5'h08, 32'h0000_00AA, 4'h1);
    bus_write(5'h18, 32'hFFFF_FFFF, 4'hF);
    @(negedge CLK);
    BUS_EN = 1'b1; BUS_WE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      BUS_ADDR = addrs[i];
      @(negedge CLK);
      checks++; if (BUS_RVALID !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, BUS_RVALID); end
      checks++; if (BUS_RDATA !== exps[i]) begin fails++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, BUS_RDATA, exps[i]); end
    end
    BUS_EN = 1'b0;
    @(negedge CLK);
    checks++; if (BUS_RVALID !== 1'b0) begin fails++; $display("FAIL b2b_end: got %b expected 0", BUS_RVALID); end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_carry();
    test_expire();
    test_msip();
    test_freeze();
    test_tick_write();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
